// File: rtl/tff_pkg.sv
// Shared types for the flip-flop bank: per-channel operating modes.
package tff_pkg;

    // Channel operating mode, selected at runtime for the whole bank.
    typedef enum logic [1:0] {
        TFF_T    = 2'b00,
        TFF_JK   = 2'b01,
        TFF_D    = 2'b10,
        TFF_HOLD = 2'b11
    } tff_mode_e;

endpackage

// File: rtl/tff_cell.sv
// One flip-flop channel: state bit, one-cycle change strobe and a
// saturating count of mode-driven changes.
module tff_cell
    import tff_pkg::*;
#(
    parameter int   CNT_W     = 4,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             load_bit,
    input  logic             en,
    input  tff_mode_e        mode,
    input  logic             a,
    input  logic             b,
    output logic             q,
    output logic             toggled,
    output logic [CNT_W-1:0] cnt
);

    logic op_q;
    logic changed;
    logic sat;

    // Next state the selected mode would produce; only used when en is high.
    always_comb begin
        op_q = q;
        case (mode)
            TFF_T:    op_q = q ^ a;
            TFF_JK: begin
                case ({a, b})
                    2'b00:   op_q = q;
                    2'b10:   op_q = 1'b1;
                    2'b01:   op_q = 1'b0;
                    default: op_q = ~q;
                endcase
            end
            TFF_D:    op_q = a;
            default:  op_q = q;
        endcase
    end

    assign changed = (op_q != q);
    assign sat     = &cnt;

    // State update with priority clear > load > enabled mode op > hold.
    // Loads and clears never raise the strobe or bump the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_BIT;
            toggled <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            q       <= RESET_BIT;
            toggled <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            q       <= load_bit;
            toggled <= 1'b0;
        end else if (en) begin
            q       <= op_q;
            toggled <= changed;
            if (changed && !sat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            toggled <= 1'b0;
        end
    end

endmodule

// File: rtl/tff_bank.sv
// Multi-channel flip-flop bank: WIDTH independent cells sharing mode,
// enable, clear and load, with packed counters and bank parity.
module tff_bank
    import tff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic                   en,
    input  tff_mode_e              mode,
    input  logic [WIDTH-1:0]       data_a,
    input  logic [WIDTH-1:0]       data_b,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qn,
    output logic [WIDTH-1:0]       toggled,
    output logic [WIDTH*CNT_W-1:0] toggle_cnt,
    output logic [WIDTH-1:0]       cnt_sat,
    output logic                   parity
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] ch_cnt;

        tff_cell #(
            .CNT_W     (CNT_W),
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .load     (load),
            .load_bit (load_val[i]),
            .en       (en),
            .mode     (mode),
            .a        (data_a[i]),
            .b        (data_b[i]),
            .q        (q[i]),
            .toggled  (toggled[i]),
            .cnt      (ch_cnt)
        );

        assign toggle_cnt[i*CNT_W +: CNT_W] = ch_cnt;
        assign cnt_sat[i]                   = &ch_cnt;
    end

    assign qn     = ~q;
    assign parity = ^q;

endmodule

// File: tb/tb_tff_bank.sv
// Directed bench for tff_bank with default parameters (8 channels, 4-bit counters).
module tb_tff_bank;
    import tff_pkg::*;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        load;
    logic [7:0]  load_val;
    logic        en;
    tff_mode_e   mode;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic [7:0]  q;
    logic [7:0]  qn;
    logic [7:0]  toggled;
    logic [31:0] toggle_cnt;
    logic [7:0]  cnt_sat;
    logic        parity;

    int checks;
    int errors;

    tff_bank #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .mode       (mode),
        .data_a     (data_a),
        .data_b     (data_b),
        .q          (q),
        .qn         (qn),
        .toggled    (toggled),
        .toggle_cnt (toggle_cnt),
        .cnt_sat    (cnt_sat),
        .parity     (parity)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] cnt_snap;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        en       = 1'b0;
        mode     = TFF_HOLD;
        data_a   = 8'h00;
        data_b   = 8'h00;
        tick();
        tick();
        check("rst_q", 64'(q), 64'h00);
        check("rst_qn", 64'(qn), 64'hFF);
        check("rst_cnt", 64'(toggle_cnt), 64'h0);
        check("rst_sat", 64'(cnt_sat), 64'h00);
        reset = 1'b0;

        // Test 1: build q=A5, cnt0=3, then reset asynchronously between edges.
        mode   = TFF_T;
        en     = 1'b1;
        data_a = 8'h01;
        tick(); tick(); tick();
        check("t1_q_pre", 64'(q), 64'h01);
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'hA5;
        tick();
        load = 1'b0;
        check("t1_q_load", 64'(q), 64'hA5);
        check("t1_cnt_pre", 64'(toggle_cnt), 64'h3);
        #2;
        reset = 1'b1;
        #1;
        check("t1_async_q", 64'(q), 64'h00);
        check("t1_async_cnt", 64'(toggle_cnt), 64'h0);
        check("t1_async_tog", 64'(toggled), 64'h00);
        check("t1_async_par", 64'(parity), 64'h0);
        tick();
        reset = 1'b0;

        // Test 2: T mode on channel 0 for 20 edges; counter saturates at 15.
        mode   = TFF_T;
        en     = 1'b1;
        data_a = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t2_q", 64'(q), 64'(k % 2));
            check("t2_tog", 64'(toggled), 64'h01);
            check("t2_cnt0", 64'(toggle_cnt[3:0]), 64'((k < 15) ? k : 15));
            check("t2_sat0", 64'(cnt_sat[0]), 64'((k >= 15) ? 1 : 0));
            check("t2_cnt_rest", 64'(toggle_cnt[31:4]), 64'h0);
        end

        // Test 3: clear, then JK with ch0..3 = 00,10,01,11.
        en    = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t3_clear_q", 64'(q), 64'h00);
        check("t3_clear_cnt", 64'(toggle_cnt), 64'h0);
        mode   = TFF_JK;
        en     = 1'b1;
        data_a = 8'b0000_1010;
        data_b = 8'b0000_1100;
        tick();
        check("t3_jk1_q", 64'(q), 64'h0A);
        check("t3_jk1_tog", 64'(toggled), 64'h0A);
        tick();
        check("t3_jk2_q", 64'(q), 64'h02);
        check("t3_jk2_tog", 64'(toggled), 64'h08);
        check("t3_jk2_cnt", 64'(toggle_cnt), 64'h0000_2010);

        // Test 4: load wins over an enabled T op; clear wins over load.
        mode     = TFF_T;
        data_a   = 8'hFF;
        load     = 1'b1;
        load_val = 8'hFF;
        tick();
        check("t4_load_q", 64'(q), 64'hFF);
        check("t4_load_tog", 64'(toggled), 64'h00);
        check("t4_load_cnt", 64'(toggle_cnt), 64'h0000_2010);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        check("t4_clr_q", 64'(q), 64'h00);
        check("t4_clr_cnt", 64'(toggle_cnt), 64'h0);
        check("t4_clr_tog", 64'(toggled), 64'h00);

        // Test 5: D mode load of 3C, then en=0 holds.
        mode   = TFF_D;
        en     = 1'b1;
        data_a = 8'h3C;
        tick();
        check("t5_d_q", 64'(q), 64'h3C);
        check("t5_d_qn", 64'(qn), 64'hC3);
        check("t5_d_tog", 64'(toggled), 64'h3C);
        check("t5_d_par", 64'(parity), 64'h0);
        check("t5_d_cnt", 64'(toggle_cnt), 64'h0011_1100);
        en     = 1'b0;
        data_a = 8'hFF;
        tick();
        check("t5_hold_q", 64'(q), 64'h3C);
        check("t5_hold_tog", 64'(toggled), 64'h00);
        check("t5_hold_cnt", 64'(toggle_cnt), 64'h0011_1100);

        // Test 6: HOLD mode with random inputs leaves everything unchanged.
        cnt_snap = 32'h0011_1100;
        mode     = TFF_HOLD;
        en       = 1'b1;
        for (int k = 0; k < 50; k++) begin
            data_a = 8'($urandom_range(0, 255));
            data_b = 8'($urandom_range(0, 255));
            tick();
            check("t6_q", 64'(q), 64'h3C);
            check("t6_tog", 64'(toggled), 64'h00);
            check("t6_cnt", 64'(toggle_cnt), 64'(cnt_snap));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
